// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the default baud divisor.
// The encoding includes StParity for builds that define UART_RX_PARITY_EN.
package uart_rx_fifo_pkg;

  // Shared with the transmitter: 100 MHz / 115200 baud.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
  localparam int unsigned UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with push/pop handshake and full/empty flags.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned     PtrW    = $clog2(Depth);
  localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // When full, the slot being written is the head being popped this same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a small FIFO read through a valid/ready port.
// Define UART_RX_PARITY_EN to receive 8E1 frames; parity and stop-bit failures share frame_err.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Rx_Serial,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned     IdxW    = $clog2(UART_DATA_BITS);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(UART_DATA_BITS - 1);

  logic                      meta_q, rxs_q;
  uart_state_e               state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      frame_ok, push, pop, fifo_full, fifo_empty;
  logic                      frame_err_q, frame_err_d, overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= Rx_Serial;
      rxs_q  <= meta_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign frame_ok = rxs_q && !(^{shift_q, parity_q});
`else
  assign frame_ok = rxs_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
`ifdef UART_RX_PARITY_EN
    parity_d    = parity_q;
`endif
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs_q;
          if (idx_q == LastIdx) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == LastCnt) begin
          cnt_d    = '0;
          parity_d = rxs_q;
          state_d  = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        // Leave at mid stop bit so a start edge right after it is not missed.
        if (cnt_q == LastCnt) begin
          cnt_d       = '0;
          state_d     = StIdle;
          push        = frame_ok;
          frame_err_d = !frame_ok;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop       = rx_valid && rx_ready;
  assign overrun_d = push && fifo_full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  sync_fifo #(
    .Width(UART_DATA_BITS),
    .Depth(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i  (clk),
    .rst_i  (reset),
    .push_i (push),
    .wdata_i(shift_q),
    .pop_i  (pop),
    .rdata_o(rx_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign rx_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit by bit, checked every cycle against a
// queue model whose push timing comes from the line timing (mid stop bit + 3 clk).
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int unsigned Cpb   = 16;
  localparam int unsigned Depth = 4;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned FrameBits = 11;
`else
  localparam int unsigned FrameBits = 10;
`endif

  logic       clk = 1'b0;
  logic       reset, rx_serial, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  uart_rx_fifo #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Rx_Serial(rx_serial),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_vec, n_err;
  logic [7:0]  model_q[$];
  int          cyc, push_at, force_pop_at, ready_mode, fe_seen, ov_seen;
  logic [7:0]  pend_byte;
  bit          pend_good, pend_active;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: choose rx_ready, advance, update the model, compare every output.
  task automatic tick();
    bit pop, push;
    bit exp_fe, exp_ov;
    if (ready_mode == 1) rx_ready = 1'b1;
    else if (ready_mode == 2) rx_ready = 1'($urandom_range(0, 1));
    else rx_ready = 1'b0;
    if (cyc + 1 == force_pop_at) rx_ready = 1'b1;
    pop    = rx_ready && (model_q.size() != 0);
    push   = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (pend_active && cyc == push_at) begin
      pend_active = 1'b0;
      if (!pend_good) exp_fe = 1'b1;
      else if (model_q.size() == Depth && !pop) exp_ov = 1'b1;
      else push = 1'b1;
    end
    if (pop) void'(model_q.pop_front());
    if (push) model_q.push_back(pend_byte);
    if (frame_err) fe_seen++;
    if (overrun) ov_seen++;
    check_eq("rx_valid", 32'(rx_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) check_eq("rx_data", 32'(rx_data), 32'(model_q[0]));
    check_eq("frame_err", 32'(frame_err), 32'(exp_fe));
    check_eq("overrun", 32'(overrun), 32'(exp_ov));
  endtask

  task automatic reset_mid_frame();
    reset     = 1'b1;
    rx_serial = 1'b1;
    #1;
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    model_q.delete();
    pend_active  = 1'b0;
    force_pop_at = -1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask

  // abort_at > 0 asserts reset that many cycles into the frame.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip,
                            input bit pop_on_push, input int abort_at);
    logic [FrameBits-1:0] bits;
    int n;
`ifdef UART_RX_PARITY_EN
    bits      = {stop_ok, (^b) ^ par_flip, b, 1'b0};
    pend_good = stop_ok && !par_flip;
`else
    bits      = {stop_ok, b, 1'b0};
    pend_good = stop_ok && !par_flip;
`endif
    pend_byte    = b;
    pend_active  = 1'b1;
    push_at      = cyc + int'((FrameBits - 1) * Cpb + Cpb / 2) + 3;
    force_pop_at = pop_on_push ? push_at : -1;
    n = 0;
    for (int i = 0; i < int'(FrameBits); i++) begin
      rx_serial = bits[i];
      for (int k = 0; k < int'(Cpb); k++) begin
        if (abort_at > 0 && n == abort_at) begin
          reset_mid_frame();
          return;
        end
        if (n == 5 * int'(Cpb)) check_eq("busy_mid_frame", 32'(busy), 32'd1);
        tick();
        n++;
      end
    end
    rx_serial = 1'b1;
  endtask

  // Pops n bytes with rx_ready held high; bytes listed LSB-first in exp_bytes.
  task automatic drain_check(input logic [31:0] exp_bytes, input int n);
    ready_mode = 1;
    for (int i = 0; i < n; i++) begin
      check_eq("drain_valid", 32'(rx_valid), 32'd1);
      check_eq("drain_byte", 32'(rx_data), 32'(exp_bytes[8*i +: 8]));
      tick();
    end
    check_eq("drain_empty", 32'(rx_valid), 32'd0);
    ready_mode = 0;
  endtask

  initial begin
    int fe0, ov0, gap;
    bit ok, pf;
    logic [7:0] b;
    n_vec = 0; n_err = 0; cyc = 0; fe_seen = 0; ov_seen = 0;
    ready_mode = 0; force_pop_at = -1; pend_active = 1'b0;
    reset = 1'b1; rx_serial = 1'b1; rx_ready = 1'b0;
    repeat (2) tick();
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_rx_data", 32'(rx_data), 32'd0);
    reset = 1'b0;
    repeat (4) tick();

    // Single good byte, consumer not ready.
    fe0 = fe_seen; ov0 = ov_seen;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
    repeat (4) tick();
    check_eq("a5_data", 32'(rx_data), 32'hA5);
    check_eq("a5_no_fe", 32'(fe_seen - fe0), 32'd0);
    check_eq("a5_no_ov", 32'(ov_seen - ov0), 32'd0);
    drain_check(32'h0000_00A5, 1);

    // Short glitch is rejected as a false start.
    fe0 = fe_seen;
    rx_serial = 1'b0;
    repeat (5) tick();
    rx_serial = 1'b1;
    for (int i = 0; i < 9 && busy; i++) tick();
    check_eq("glitch_busy", 32'(busy), 32'd0);
    check_eq("glitch_no_fe", 32'(fe_seen - fe0), 32'd0);
    check_eq("glitch_no_byte", 32'(rx_valid), 32'd0);

    // Stop bit low.
    fe0 = fe_seen;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
    repeat (Cpb + 4) tick();
    check_eq("stop_low_fe", 32'(fe_seen - fe0), 32'd1);
    check_eq("stop_low_no_byte", 32'(rx_valid), 32'd0);

    // Five back-to-back bytes into a 4-deep FIFO.
    ov0 = ov_seen;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 0);
    repeat (4) tick();
    check_eq("overrun_once", 32'(ov_seen - ov0), 32'd1);
    drain_check(32'h0403_0201, 4);

    // Full FIFO with a pop on the push cycle: no overrun.
    ov0 = ov_seen;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 0);
    send_frame(8'h06, 1'b1, 1'b0, 1'b1, 0);
    repeat (4) tick();
    check_eq("full_pop_push_no_ov", 32'(ov_seen - ov0), 32'd0);
    drain_check(32'h0604_0302, 4);

    // Reset during DATA with a byte buffered, then a clean frame.
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 3 * Cpb + 5);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 0);
    repeat (4) tick();
    check_eq("after_reset_data", 32'(rx_data), 32'h5A);
    drain_check(32'h0000_005A, 1);

`ifdef UART_RX_PARITY_EN
    fe0 = fe_seen;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 0);
    repeat (Cpb + 4) tick();
    check_eq("parity_fe", 32'(fe_seen - fe0), 32'd1);
    check_eq("parity_no_byte", 32'(rx_valid), 32'd0);
`endif

    // Random frames with a randomly stalling consumer.
    ready_mode = 2;
    for (int f = 0; f < 16; f++) begin
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 4) != 0);
      pf  = 1'b0;
`ifdef UART_RX_PARITY_EN
      pf  = ($urandom_range(0, 5) == 0);
`endif
      send_frame(b, ok, pf, 1'b0, 0);
      gap = $urandom_range(0, 3) * 4;
      if (!ok) gap += Cpb;
      repeat (gap) tick();
    end
    ready_mode = 1;
    for (int i = 0; i < 4 * int'(Depth) && model_q.size() != 0; i++) tick();
    check_eq("random_drained", 32'(rx_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver: the inbound end of the serial link; the bus transmitter drives Tx_Serial, this block decodes Rx_Serial.
- Sits inside the bus next to the transmitter.
- Deserialises 8N1 frames (LSB first) and buffers bytes in a small FIFO.
- Presents buffered bytes to the bus with a valid/ready handshake, plus single-cycle error pulses.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); must be >= 8.
- FIFO_DEPTH, 4, receive buffer entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Rx_Serial  in  1  serial line, idle high, asynchronous to clk
- rx_data  out  8  byte at FIFO head; valid only while rx_valid=1
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts head byte this cycle
- frame_err  out  1  one-cycle pulse: stop bit sampled low (or parity error, see Optional Feature)
- overrun  out  1  one-cycle pulse: completed byte dropped because FIFO full
- busy  out  1  receiver FSM not in IDLE

Behaviour:
- Reset (async, high): all state cleared.
  - FSM goes to IDLE, bit and cycle counters to 0, FIFO empty.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops reset to 1 (idle line).
  - Reset mid-frame aborts the frame; no partial byte is ever pushed.
- Rx_Serial passes through a 2-flop synchroniser; all decoding uses the synchronised signal rxs.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: rxs==0 -> START, cycle counter cleared.
- START: count to (CLKS_PER_BIT-1)/2, then sample rxs.
  - rxs==1: false start -> IDLE, nothing reported.
  - rxs==0: -> DATA, counter cleared, bit index 0.
- DATA: each time the counter reaches CLKS_PER_BIT-1, sample rxs into shift[bit_index] (LSB first).
  - After bit 7 is sampled -> STOP.
- STOP: sample once after CLKS_PER_BIT-1 cycles, i.e. at mid stop bit.
  - rxs==1: push the byte.
  - rxs==0: pulse frame_err for 1 cycle, discard the byte.
  - Either way return to IDLE in the same cycle; a following start edge is detected without waiting a full stop bit.
- Push timing: push occurs on the sample cycle; rx_valid rises the next cycle if the FIFO was empty.
  - End-to-end latency from the mid stop bit on Rx_Serial to rx_valid is 3 clk (2 sync + 1 register).
- FIFO: circular buffer, read/write pointers of log2(FIFO_DEPTH) bits, count of log2(FIFO_DEPTH)+1 bits.
  - rx_data is driven from the head entry.
  - Pop occurs when rx_valid && rx_ready; rx_ready while empty is ignored.
  - Push when full and no pop in the same cycle: byte dropped, overrun pulses 1 cycle, FIFO contents unchanged.
  - Push and pop in the same cycle: both happen, count unchanged, including when full (no overrun).
  - Pointers wrap modulo FIFO_DEPTH.
- frame_err and overrun are mutually exclusive per frame; a framing error never pushes.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined: frame is 8E1. FSM gains a PARITY state between DATA and STOP.
  - The parity bit is sampled there; the byte is pushed only if XOR(data, parity)==0 and the stop bit is 1.
  - Otherwise frame_err pulses (parity fail and bad stop bit share the pulse) and the byte is discarded.
- When undefined: 8N1 exactly as above; no PARITY state or logic.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/START/DATA/PARITY/STOP, 3-bit).
  - Default baud constant CLKS_PER_BIT_DEFAULT=868, shared with the transmitter.
  - UART_DATA_BITS=8.
- One natural sub-module: sync_fifo (parameterised width and depth; push/pop/full/empty/count), instantiated once for the receive buffer.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Send 0xA5 with a good stop bit, rx_ready=0 -> rx_valid rises 3 clk after the mid stop bit, rx_data=0xA5; frame_err=0, overrun=0.
- Glitch: Rx_Serial low for 5 clk then high -> no byte, busy returns to 0 within 9 clk, no error pulse.
- Send 0x3C with stop bit held low -> one frame_err pulse, rx_valid stays 0.
- Send 5 bytes 0x01..0x05 back-to-back, rx_ready=0 -> FIFO holds 0x01..0x04, one overrun pulse on the 5th; draining with rx_ready=1 yields 0x01,0x02,0x03,0x04, then rx_valid=0.
- FIFO full, then pop on the exact cycle 0x06 is pushed -> no overrun; drain order 0x02,0x03,0x04,0x06.
- Assert reset during DATA of 0xFF -> all outputs 0 immediately; after release, send 0x5A -> rx_data=0x5A. With UART_RX_PARITY_EN defined: 0x5A with parity bit 1 -> frame_err pulse, no push.
